// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared state encoding, default sizes and PWM bus index helpers
//            for the per-phase gate sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

   localparam int N_SM_DEFAULT = 24;
   localparam int DT_W_DEFAULT = 8;

   // Sequencer states; encoding is visible on the state output port
   typedef enum logic [1:0] {
      ST_BLOCKED = 2'd0,
      ST_ARMING  = 2'd1,
      ST_RUN     = 2'd2,
      ST_FAULT   = 2'd3
   } pwm_state_t;

   // Bus position of the A (upper) switch of submodule sm
   function automatic int sm_a_idx(input int sm);
      return 2 * sm + 1;
   endfunction

   // Bus position of the B (lower) switch of submodule sm
   function automatic int sm_b_idx(input int sm);
      return 2 * sm;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_sm_deadtime.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sm_deadtime
// Brief    : One submodule's switching target, dead-time counter and
//            registered complementary A/B gate pair.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_sm_deadtime
   import pwm_pkg::*;
#(
   parameter int DT_W = DT_W_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            preset,     // take cmd as target with no dead time
   input  logic            load,       // run-time command strobe
   input  logic            cmd,        // 1 = inserted (A on), 0 = bypassed (B on)
   input  logic [DT_W-1:0] dt,         // effective dead time, always >= 1
   input  logic            force_off,  // sequencer is not in RUN next cycle
   output logic            gate_a,
   output logic            gate_b,
   output logic            busy
);

   localparam logic [DT_W-1:0] c_DT_ONE = {{(DT_W-1){1'b0}}, 1'b1};

   logic            r_tgt;
   logic [DT_W-1:0] r_cnt;
   logic            r_a;
   logic            r_b;
   logic            w_change;
   logic            w_tgt_src;

   // A run-time command only matters when it differs from the current target;
   // a preset target drives the gates straight away on the arming exit edge
   always_comb begin
      w_change  = load && (cmd != r_tgt);
      w_tgt_src = preset ? cmd : r_tgt;
   end

   // Target, dead-time counter and gate registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tgt <= 1'b0;
         r_cnt <= '0;
         r_a   <= 1'b0;
         r_b   <= 1'b0;
      end else begin
         if (preset || w_change) begin
            r_tgt <= cmd;
         end

         // A retoggle mid-count reloads the full dead time
         if (force_off) begin
            r_cnt <= '0;
         end else if (w_change) begin
            r_cnt <= dt;
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_DT_ONE;
         end

         // Gates follow the counter value before this edge, so a change
         // sampled now turns both switches off from the following edge
         if (force_off || (r_cnt != '0)) begin
            r_a <= 1'b0;
            r_b <= 1'b0;
         end else begin
            r_a <= w_tgt_src;
            r_b <= ~w_tgt_src;
         end
      end
   end

   assign gate_a = r_a;
   assign gate_b = r_b;
   assign busy   = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/pwm_phase_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_phase_gate_ctrl
// Brief    : Per-phase gating sequencer: block/arm/run/fault control around
//            N_SM dead-time submodules producing the 2*N_SM PWM gate bus.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_phase_gate_ctrl
   import pwm_pkg::*;
#(
   parameter int N_SM = N_SM_DEFAULT,
   parameter int DT_W = DT_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              fault,
   input  logic              fault_clr,
   input  logic [DT_W-1:0]   dt_cfg,
   input  logic              cmd_valid,
   input  logic [N_SM-1:0]   sm_cmd,
   output logic [2*N_SM-1:0] pwm_bus,
   output logic [1:0]        state,
   output logic              busy
);

   localparam logic [DT_W-1:0] c_DT_ONE = {{(DT_W-1){1'b0}}, 1'b1};

   pwm_state_t      r_state;
   pwm_state_t      w_state_nxt;
   logic [DT_W-1:0] r_arm_cnt;
   logic [DT_W-1:0] w_dt_eff;
   logic            w_arm_load;
   logic            w_sm_preset;
   logic            w_sm_load;
   logic            w_force_off;
   logic [N_SM-1:0] w_sm_a;
   logic [N_SM-1:0] w_sm_b;
   logic [N_SM-1:0] w_sm_busy;

   // A programmed dead time of zero still needs one cycle of both-off
   assign w_dt_eff = (dt_cfg == '0) ? c_DT_ONE : dt_cfg;

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_BLOCKED;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and submodule controls; fault beats disable beats commands
   always_comb begin
      w_state_nxt = r_state;
      w_arm_load  = 1'b0;
      w_sm_preset = 1'b0;
      w_sm_load   = 1'b0;
      w_force_off = 1'b1;
      if (fault) begin
         w_state_nxt = ST_FAULT;
      end else begin
         case (r_state)
            ST_BLOCKED: begin
               if (enable) begin
                  w_state_nxt = ST_ARMING;
                  w_arm_load  = 1'b1;
                  w_sm_preset = 1'b1;
               end
            end
            ST_ARMING: begin
               if (!enable) begin
                  w_state_nxt = ST_BLOCKED;
               end else begin
                  w_sm_preset = cmd_valid;
                  if (r_arm_cnt <= c_DT_ONE) begin
                     w_state_nxt = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (!enable) begin
                  w_state_nxt = ST_BLOCKED;
               end else begin
                  w_sm_load = cmd_valid;
               end
            end
            ST_FAULT: begin
               if (fault_clr) begin
                  w_state_nxt = ST_BLOCKED;
               end
            end
            default: begin
               w_state_nxt = ST_BLOCKED;
            end
         endcase
      end
      // Gates are only ever released in RUN; decided from the next state so
      // fault and disable blank the bus on the very edge they take effect
      w_force_off = (w_state_nxt != ST_RUN);
   end

   // Arming interval counter: loaded on entry, counts down while arming
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_arm_cnt <= '0;
      end else if (w_arm_load) begin
         r_arm_cnt <= w_dt_eff;
      end else if (w_state_nxt == ST_ARMING) begin
         r_arm_cnt <= r_arm_cnt - c_DT_ONE;
      end else begin
         r_arm_cnt <= '0;
      end
   end

   // One dead-time slice per submodule, gates placed A-above-B on the bus
   for (genvar gi = 0; gi < N_SM; gi++) begin : g_sm
      localparam int c_IDX_A = sm_a_idx(gi);
      localparam int c_IDX_B = sm_b_idx(gi);

      pwm_sm_deadtime #(
         .DT_W (DT_W)
      ) u_sm (
         .clk       (clk),
         .rst_n     (rst_n),
         .preset    (w_sm_preset),
         .load      (w_sm_load),
         .cmd       (sm_cmd[gi]),
         .dt        (w_dt_eff),
         .force_off (w_force_off),
         .gate_a    (w_sm_a[gi]),
         .gate_b    (w_sm_b[gi]),
         .busy      (w_sm_busy[gi])
      );

      assign pwm_bus[c_IDX_A] = w_sm_a[gi];
      assign pwm_bus[c_IDX_B] = w_sm_b[gi];
   end

   assign state = r_state;
   assign busy  = (r_state == ST_ARMING) || (|w_sm_busy);

endmodule
`default_nettype wire

// File: tb/tb_pwm_phase_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_phase_gate_ctrl
// Brief    : Directed self-checking bench for the per-phase gate sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_phase_gate_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        fault;
   logic        fault_clr;
   logic [7:0]  dt_cfg;
   logic        cmd_valid;
   logic [23:0] sm_cmd;
   logic [47:0] pwm_bus;
   logic [1:0]  state;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   pwm_phase_gate_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .fault     (fault),
      .fault_clr (fault_clr),
      .dt_cfg    (dt_cfg),
      .cmd_valid (cmd_valid),
      .sm_cmd    (sm_cmd),
      .pwm_bus   (pwm_bus),
      .state     (state),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Expected steady-state bus for a target vector: A=cmd, B=~cmd per pair
   function automatic logic [47:0] expand(input logic [23:0] c);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 24; i++) begin
         r[2*i+1] = c[i];
         r[2*i]   = ~c[i];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Shoot-through watchdog, every cycle
   always @(negedge clk) begin
      checks++;
      if (((pwm_bus >> 1) & pwm_bus & 48'h555555555555) !== 48'h0) begin
         failures++;
         $display("FAIL shoot_through bus=%h", pwm_bus);
      end
   end

   task automatic test_reset_arm();
      rst_n = 1'b0; enable = 1'b0; fault = 1'b0; fault_clr = 1'b0;
      dt_cfg = 8'd5; cmd_valid = 1'b0; sm_cmd = 24'hFFF000;
      tick(); tick();
      checks++;
      if (pwm_bus !== 48'h0 || state !== 2'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset bus=%h state=%0d busy=%b want 0/0/0", pwm_bus, state, busy);
      end
      rst_n = 1'b1; enable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (state !== 2'd1 || pwm_bus !== 48'h0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL arming k=%0d state=%0d bus=%h busy=%b want 1/0/1", k, state, pwm_bus, busy);
         end
      end
      tick();
      checks++;
      if (state !== 2'd2 || pwm_bus !== 48'hAAAAAA555555 || busy !== 1'b0) begin
         failures++;
         $display("FAIL first_run state=%0d bus=%h busy=%b want 2/aaaaaa555555/0", state, pwm_bus, busy);
      end
   endtask

   task automatic test_deadtime();
      logic [47:0] exp_bus [5];
      logic        exp_busy [5];
      exp_bus  = '{48'hAAAAAA555555, 48'hAAAAAA555554, 48'hAAAAAA555554,
                   48'hAAAAAA555554, 48'hAAAAAA555556};
      exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      dt_cfg = 8'd3; sm_cmd = 24'hFFF001; cmd_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         cmd_valid = 1'b0;
         checks++;
         if (pwm_bus !== exp_bus[k] || busy !== exp_busy[k]) begin
            failures++;
            $display("FAIL deadtime t+%0d bus=%h busy=%b want %h/%b", k, pwm_bus, busy, exp_bus[k], exp_busy[k]);
         end
      end
   endtask

   task automatic test_retrigger();
      logic [1:0]  exp_pair;
      logic [47:0] rest_mask;
      rest_mask = ~48'h000000000C00;
      dt_cfg = 8'd4; sm_cmd = 24'hFFF021; cmd_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         cmd_valid = 1'b0;
         if (k == 1) begin
            sm_cmd = 24'hFFF001; cmd_valid = 1'b1;
         end
         exp_pair = (k == 0 || k == 7) ? 2'b01 : 2'b00;
         checks++;
         if (pwm_bus[11:10] !== exp_pair ||
             (pwm_bus & rest_mask) !== (48'hAAAAAA555556 & rest_mask)) begin
            failures++;
            $display("FAIL retrigger t+%0d bus=%h want pair %b", k, pwm_bus, exp_pair);
         end
      end
   endtask

   task automatic test_dt_zero();
      logic [1:0] exp_pair [3];
      exp_pair = '{2'b10, 2'b00, 2'b01};
      dt_cfg = 8'd0; sm_cmd = 24'h7FF001; cmd_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         cmd_valid = 1'b0;
         checks++;
         if (pwm_bus[47:46] !== exp_pair[k]) begin
            failures++;
            $display("FAIL dt_zero t+%0d pair=%b want %b", k, pwm_bus[47:46], exp_pair[k]);
         end
      end
      checks++;
      if (pwm_bus !== expand(24'h7FF001) || busy !== 1'b0) begin
         failures++;
         $display("FAIL dt_zero_bus bus=%h busy=%b want %h/0", pwm_bus, busy, expand(24'h7FF001));
      end
   endtask

   task automatic test_fault();
      dt_cfg = 8'd5; sm_cmd = 24'h7FF003; cmd_valid = 1'b1;
      tick(); cmd_valid = 1'b0;
      tick();
      fault = 1'b1;
      tick();
      checks++;
      if (pwm_bus !== 48'h0 || state !== 2'd3 || busy !== 1'b0) begin
         failures++;
         $display("FAIL fault_entry bus=%h state=%0d busy=%b want 0/3/0", pwm_bus, state, busy);
      end
      fault_clr = 1'b1;
      tick(); fault_clr = 1'b0;
      checks++;
      if (state !== 2'd3) begin
         failures++;
         $display("FAIL fault_clr_ignored state=%0d want 3", state);
      end
      fault = 1'b0;
      tick();
      checks++;
      if (state !== 2'd3 || pwm_bus !== 48'h0) begin
         failures++;
         $display("FAIL fault_hold state=%0d bus=%h want 3/0", state, pwm_bus);
      end
      enable = 1'b0; fault_clr = 1'b1;
      tick(); fault_clr = 1'b0;
      checks++;
      if (state !== 2'd0 || pwm_bus !== 48'h0) begin
         failures++;
         $display("FAIL fault_release state=%0d bus=%h want 0/0", state, pwm_bus);
      end
      tick();
      checks++;
      if (state !== 2'd0) begin
         failures++;
         $display("FAIL blocked_hold state=%0d want 0", state);
      end
      enable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (state !== 2'd1 || pwm_bus !== 48'h0) begin
            failures++;
            $display("FAIL rearm k=%0d state=%0d bus=%h want 1/0", k, state, pwm_bus);
         end
      end
      tick();
      checks++;
      if (state !== 2'd2 || pwm_bus !== expand(24'h7FF003)) begin
         failures++;
         $display("FAIL rerun state=%0d bus=%h want 2/%h", state, pwm_bus, expand(24'h7FF003));
      end
   endtask

   task automatic test_disable_and_arm_cmd();
      sm_cmd = 24'h7FF007; cmd_valid = 1'b1;
      tick(); cmd_valid = 1'b0;
      enable = 1'b0;
      tick();
      checks++;
      if (state !== 2'd0 || pwm_bus !== 48'h0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL disable state=%0d bus=%h busy=%b want 0/0/0", state, pwm_bus, busy);
      end
      enable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         cmd_valid = 1'b0;
         if (k == 1) begin
            sm_cmd = 24'h0F0F0F; cmd_valid = 1'b1;
         end
         checks++;
         if (state !== 2'd1 || pwm_bus !== 48'h0) begin
            failures++;
            $display("FAIL arm_cmd k=%0d state=%0d bus=%h want 1/0", k, state, pwm_bus);
         end
      end
      tick();
      checks++;
      if (state !== 2'd2 || pwm_bus !== expand(24'h0F0F0F) || busy !== 1'b0) begin
         failures++;
         $display("FAIL arm_cmd_run state=%0d bus=%h busy=%b want 2/%h/0", state, pwm_bus, busy, expand(24'h0F0F0F));
      end
   endtask

   task automatic test_random_toggles();
      logic [23:0] last;
      last = 24'h0F0F0F;
      for (int k = 0; k < 300; k++) begin
         dt_cfg    = 8'($urandom_range(0, 3));
         sm_cmd    = 24'($urandom);
         cmd_valid = ($urandom_range(0, 3) == 0);
         if (cmd_valid) last = sm_cmd;
         tick();
      end
      cmd_valid = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      checks++;
      if (state !== 2'd2 || pwm_bus !== expand(last) || busy !== 1'b0) begin
         failures++;
         $display("FAIL random_settle state=%0d bus=%h busy=%b want 2/%h/0", state, pwm_bus, busy, expand(last));
      end
   endtask

   task automatic test_midrun_reset();
      rst_n = 1'b0;
      tick();
      checks++;
      if (pwm_bus !== 48'h0 || state !== 2'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midrun_reset bus=%h state=%0d busy=%b want 0/0/0", pwm_bus, state, busy);
      end
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset_arm();
      test_deadtime();
      test_retrigger();
      test_dt_zero();
      test_fault();
      test_disable_and_arm_cmd();
      test_random_toggles();
      test_midrun_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pwm_phase_gate_ctrl.md
Name: pwm_phase_gate_ctrl

Overview:
- Per-phase gating sequencer producing the 48-bit PWM bus (24 submodules × A/B switch pair) consumed by the bus-to-pin conversion stage.
- Converts a 24-bit submodule insertion command into complementary A/B gate signals with programmable dead time.
- Handles a block/arm/run/fault sequence so that gates only release after a clean arming interval and drop immediately on fault.
- Instantiated three times (phases A, B, C) in the top level.

Parameters:
- N_SM, 24, submodules per phase; bus width is 2*N_SM.
- DT_W, 8, width of the dead-time count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- enable  in  1  request to release gates; level-sensitive
- fault  in  1  fault input; level-sensitive, highest priority
- fault_clr  in  1  single-cycle pulse; acknowledges a latched fault
- dt_cfg  in  DT_W  dead time in clk cycles; values 0 and 1 both mean 1 cycle
- cmd_valid  in  1  strobe; sample sm_cmd this cycle
- sm_cmd  in  N_SM  bit i set = submodule inserted (A on, B off); clear = bypassed (A off, B on)
- pwm_bus  out  2*N_SM  registered gates; pwm_bus[2i+1] = A and pwm_bus[2i] = B of the submodule at sm_cmd[i]; sm_cmd[N_SM-1] is submodule 1
- state  out  2  0=BLOCKED, 1=ARMING, 2=RUN, 3=FAULT
- busy  out  1  high while any submodule counter is non-zero, or while in ARMING

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active low.
- Reset values: pwm_bus=0, state=BLOCKED, busy=0, all targets=0, all counters=0.
- Effective dead time: D = max(dt_cfg, 1).
- BLOCKED:
  - pwm_bus=0.
  - Moves to ARMING when enable=1 and fault=0.
  - On that entry edge, the targets are loaded from sm_cmd regardless of cmd_valid, and the arm counter is loaded with D.
- ARMING:
  - pwm_bus=0; the arm counter decrements each cycle.
  - When it reaches 0, moves to RUN; the first RUN cycle drives the targets directly, with no extra dead time.
  - enable=0 returns to BLOCKED.
  - cmd_valid in ARMING updates the targets without restarting the arm counter.
- RUN:
  - When cmd_valid=1, bit i of sm_cmd is compared with target[i].
  - If they differ: target[i] is updated, counter[i] is loaded with D, and both A and B go to 0 from the next edge.
  - A submodule with counter[i]≠0 holds A=B=0 and decrements. When the counter reaches 0, the next edge drives A=target, B=~target.
  - Latency: cmd_valid sampled at edge t → both gates off from edge t+1 → new side on at edge t+1+D.
  - A toggle while counter[i]≠0 updates target[i] and reloads the counter with D, restarting the dead time. The outputs stay 0 throughout.
  - cmd_valid with an unchanged bit: no effect on that submodule.
  - dt_cfg is sampled per submodule at load time; changing it mid-count does not affect running counters.
  - enable=0: next edge → BLOCKED with pwm_bus=0; counters are cleared.
- FAULT:
  - fault=1 in any state except reset moves to FAULT at the next edge. pwm_bus=0 from that same edge; counters are cleared.
  - FAULT is held until fault_clr=1 with fault=0; it then goes to BLOCKED, never straight to RUN.
  - fault_clr while fault=1 is ignored.
- Priority: rst_n > fault > enable=0 > cmd_valid.
- Invariant: A and B of any submodule are never both 1, in any state or cycle.

Decomposition:
- Shared package pwm_pkg holds:
  - state encoding constants ST_BLOCKED, ST_ARMING, ST_RUN, ST_FAULT;
  - N_SM_DEFAULT=24 and DT_W_DEFAULT=8;
  - the bus bit-index helpers for A and B.
- One sub-module, pwm_sm_deadtime: a single submodule's target register, counter and A/B output register.
  - Inputs: load, cmd bit, dt value, force_off.
  - Instantiated N_SM times by a generate loop. The top holds the FSM and the arm counter.

Test Plan:
- Reset/arm: rst_n low 2 cycles, dt_cfg=5, sm_cmd=24'hFFF000, enable=1 → state ARMING for 5 cycles with pwm_bus=0, then RUN with pwm_bus[47:24]=24'hAAAAAA and pwm_bus[23:0]=24'h555555.
- Dead time: in RUN with dt_cfg=3, flip sm_cmd[0] 0→1 with cmd_valid at edge t → pwm_bus[1:0]=01 until t, 00 for edges t+1..t+3, 10 from edge t+4; other bits unchanged; busy high for 3 cycles.
- Retrigger: flip sm_cmd[5] at t, then flip it back at t+2 with dt_cfg=4 → pwm_bus[11:10]=00 from t+1 through t+6, original value restored at t+7.
- dt_cfg=0: one toggle → exactly 1 cycle of 00 before the new side turns on.
- Fault mid-deadtime: fault=1 during counts → pwm_bus=0 next edge, state=3. fault_clr with fault=1 → stays in FAULT. fault=0 then fault_clr → BLOCKED, and ARMING is re-entered only while enable=1.
- Randomised toggles plus an assertion: for all i, at no cycle is pwm_bus[2i+1] & pwm_bus[2i] = 1; mid-run reset → all outputs 0 at the next edge.
